// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_pkg
//  Description : Shared definitions for the Common Data Bus producer:
//                opcode encodings, functional-unit indices, the broadcast
//                message record and a small round-robin index helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cdb_pkg;

  // Opcode encodings used by the issue stage
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_SD  = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;

  // Functional-unit result port indices (lower index = higher fixed priority)
  localparam int FU_ADD  = 0;
  localparam int FU_MUL  = 1;
  localparam int FU_LDST = 2;

  // Default bus geometry
  localparam int CDB_TAG_W  = 3;
  localparam int CDB_REG_W  = 3;
  localparam int CDB_DATA_W = 16;

  // One broadcast / one holding-slot payload
  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_REG_W-1:0]  dest;
    logic [CDB_DATA_W-1:0] data;
    logic                  wr;
  } cdb_msg_t;

  // Index following idx in a ring of n entries
  function automatic int nextIdx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : cdb_pkg
`default_nettype wire

// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_rr_arbiter
//  Description : One-hot grant generator for the CDB. Default build is
//                round-robin: the search starts at r_ptr, which holds the
//                index just after the most recently granted unit.
//                With CDB_FIXED_PRIO_EN defined the pointer is removed and
//                the lowest requesting index always wins.
//  Ports       : clock, reset_n  - clock / async active-low reset
//                req[N_FU]       - per-unit request (slot full, not flushing)
//                grantTaken      - a grant is being consumed this cycle
//                grant[N_FU]     - one-hot grant, combinational on req
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_rr_arbiter
  import cdb_pkg::*;
#(
  parameter int N_FU = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N_FU-1:0] req,
  input  logic            grantTaken,
  output logic [N_FU-1:0] grant
);

`ifdef CDB_FIXED_PRIO_EN

  // Scan from the top down so the lowest requesting index is left standing
  always_comb begin
    grant = '0;
    for (int i = N_FU - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  logic w_unusedPorts;
  assign w_unusedPorts = clock ^ reset_n ^ grantTaken;

`else

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_grantIdx;
  logic             w_found;

  // Walk the ring starting at r_ptr; first requester wins
  always_comb begin
    grant      = '0;
    w_grantIdx = '0;
    w_found    = 1'b0;
    for (int k = 0; k < N_FU; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % N_FU]) begin
        w_found                           = 1'b1;
        grant[(int'(r_ptr) + k) % N_FU]   = 1'b1;
        w_grantIdx                        = PTR_W'((int'(r_ptr) + k) % N_FU);
      end
    end
  end

  // Pointer only moves when a grant is actually consumed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (grantTaken) begin
      r_ptr <= PTR_W'(nextIdx(int'(w_grantIdx), N_FU));
    end
  end

`endif

endmodule : cdb_rr_arbiter
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Producer end of the Common Data Bus. Each functional unit
//                owns one holding slot; one full slot is granted per cycle
//                and broadcast through a registered output stage. The bus
//                has no backpressure.
//  Config      : CDB_FIXED_PRIO_EN - fixed priority (lowest index wins)
//                instead of the default round-robin.
//  Ports       : clock, reset_n, flush
//                fu_valid/fu_ready/fu_tag/fu_dest/fu_data/fu_wr - unit side
//                cdb_valid/cdb_tag/cdb_dest/cdb_data/cdb_wr_en/cdb_src - bus
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_FU   = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int REG_W  = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [N_FU-1:0]          fu_valid,
  output logic [N_FU-1:0]          fu_ready,
  input  logic [N_FU*TAG_W-1:0]    fu_tag,
  input  logic [N_FU*REG_W-1:0]    fu_dest,
  input  logic [N_FU*DATA_W-1:0]   fu_data,
  input  logic [N_FU-1:0]          fu_wr,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [REG_W-1:0]         cdb_dest,
  output logic [DATA_W-1:0]        cdb_data,
  output logic                     cdb_wr_en,
  output logic [N_FU-1:0]          cdb_src
);

  // Holding slots
  logic [N_FU-1:0]   r_full;
  logic [TAG_W-1:0]  r_slotTag  [N_FU];
  logic [REG_W-1:0]  r_slotDest [N_FU];
  logic [DATA_W-1:0] r_slotData [N_FU];
  logic [N_FU-1:0]   r_slotWr;

  // Broadcast registers
  logic              r_cdbValid;
  logic [TAG_W-1:0]  r_cdbTag;
  logic [REG_W-1:0]  r_cdbDest;
  logic [DATA_W-1:0] r_cdbData;
  logic              r_cdbWrEn;
  logic [N_FU-1:0]   r_cdbSrc;

  logic [N_FU-1:0]   w_req;
  logic [N_FU-1:0]   w_grant;
  logic [N_FU-1:0]   w_ready;
  logic [N_FU-1:0]   w_accept;
  logic [TAG_W-1:0]  w_selTag;
  logic [REG_W-1:0]  w_selDest;
  logic [DATA_W-1:0] w_selData;
  logic              w_selWr;

  // A flushing cycle must neither grant nor accept, so requests are masked
  assign w_req = flush ? '0 : r_full;

  cdb_rr_arbiter #(
    .N_FU       (N_FU)
  ) u_arb (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (w_req),
    .grantTaken (|w_grant),
    .grant      (w_grant)
  );

  // A granted slot empties at the same edge, so it can refill without a bubble
  assign w_ready  = flush ? '0 : (~r_full | w_grant);
  assign w_accept = fu_valid & w_ready;
  assign fu_ready = w_ready;

  // Payload of the granted slot (grant is one-hot)
  always_comb begin
    w_selTag  = '0;
    w_selDest = '0;
    w_selData = '0;
    w_selWr   = 1'b0;
    for (int i = 0; i < N_FU; i++) begin
      if (w_grant[i]) begin
        w_selTag  = r_slotTag[i];
        w_selDest = r_slotDest[i];
        w_selData = r_slotData[i];
        w_selWr   = r_slotWr[i];
      end
    end
  end

  // Slot storage: accept has precedence over grant-clear, which is what
  // keeps the old result broadcasting while the new one is captured.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full   <= '0;
      r_slotWr <= '0;
      for (int i = 0; i < N_FU; i++) begin
        r_slotTag[i]  <= '0;
        r_slotDest[i] <= '0;
        r_slotData[i] <= '0;
      end
    end else if (flush) begin
      r_full <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (w_accept[i]) begin
          r_full[i]     <= 1'b1;
          r_slotTag[i]  <= fu_tag[i*TAG_W +: TAG_W];
          r_slotDest[i] <= fu_dest[i*REG_W +: REG_W];
          r_slotData[i] <= fu_data[i*DATA_W +: DATA_W];
          r_slotWr[i]   <= fu_wr[i];
        end else if (w_grant[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  // Output stage: tag/dest/data hold their last value on idle cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cdbValid <= 1'b0;
      r_cdbWrEn  <= 1'b0;
      r_cdbTag   <= '0;
      r_cdbDest  <= '0;
      r_cdbData  <= '0;
      r_cdbSrc   <= '0;
    end else begin
      r_cdbValid <= |w_grant;
      r_cdbWrEn  <= (|w_grant) & w_selWr;
      r_cdbSrc   <= w_grant;
      if (|w_grant) begin
        r_cdbTag  <= w_selTag;
        r_cdbDest <= w_selDest;
        r_cdbData <= w_selData;
      end
    end
  end

  assign cdb_valid = r_cdbValid;
  assign cdb_tag   = r_cdbTag;
  assign cdb_dest  = r_cdbDest;
  assign cdb_data  = r_cdbData;
  assign cdb_wr_en = r_cdbWrEn;
  assign cdb_src   = r_cdbSrc;

endmodule : cdb_arbiter
`default_nettype wire
